mem_bist_initiator: RTL and testbench

//  Bus initiator for the mem_if SRAM protocol; it drives we/addr/wdata and samples rdata.
//  On a start pulse it writes a seeded pattern to a window of addresses, then reads the window back.
//  It compares each readback word and reports done, error count and first failing address.

---
 rtl/mem_bist_initiator_pkg.sv | 11 +
 rtl/mem_bist_initiator_if.sv | 10 +
 rtl/mem_bist_initiator_rd_cmp_pipe.sv | 42 ++++
 rtl/mem_bist_initiator.sv | 103 ++++++++++
 tb/tb_mem_bist_initiator.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_initiator_pkg.sv
// mem_bist_initiator_pkg: shared widths, types and FSM states for the memory BIST initiator
package mem_bist_initiator_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} bist_state_e;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0] len_t;
    localparam len_t MEM_WORDS = len_t'(1 << ADDR_W);
endpackage

// File: rtl/mem_bist_initiator_if.sv
// mem_bist_initiator_if: single-port SRAM bus between the initiator and the memory
interface mem_bist_initiator_if;
    import mem_bist_initiator_pkg::*;
    logic  we;
    addr_t addr;
    data_t wdata;
    data_t rdata;
    modport master(output we, addr, wdata, input rdata);
    modport slave(input we, addr, wdata, output rdata);
endinterface

// File: rtl/mem_bist_initiator_rd_cmp_pipe.sv
// mem_bist_initiator_rd_cmp_pipe: delays read expectations to meet rdata and flags mismatches
module mem_bist_initiator_rd_cmp_pipe
    import mem_bist_initiator_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  addr_t in_addr,
    input  data_t in_exp,
    input  data_t rdata,
    output logic  mis,
    output addr_t mis_addr
);
    logic  v [LAT];
    addr_t a [LAT];
    data_t e [LAT];
    // shift outstanding reads and register the compare of the oldest one against rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                v[i] <= 1'b0;
                a[i] <= '0;
                e[i] <= '0;
            end
            mis      <= 1'b0;
            mis_addr <= '0;
        end else begin
            v[0] <= in_valid;
            a[0] <= in_addr;
            e[0] <= in_exp;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
                e[i] <= e[i-1];
            end
            mis      <= v[LAT-1] && (rdata != e[LAT-1]);
            mis_addr <= a[LAT-1];
        end
    end
endmodule

// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator: writes a seeded ramp to an SRAM window, reads it back and counts mismatches
module mem_bist_initiator
    import mem_bist_initiator_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  addr_t base,
    input  len_t  len,
    input  data_t seed,
    output logic  busy,
    output logic  done,
    output len_t  err_cnt,
    output addr_t first_err_addr,
    mem_bist_initiator_if.master mem
);
    bist_state_e state, state_n;
    len_t  idx, idx_n, len_q, len_c;
    addr_t base_q, base_c, addr_q, mis_addr;
    data_t seed_q, seed_c, wdata_q, rd_exp;
    logic  we_q, mis;

    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    // next state; run parameters come straight from the inputs while idle so the first write needs no extra cycle
    always_comb begin
        base_c  = state == IDLE ? base : base_q;
        seed_c  = state == IDLE ? seed : seed_q;
        len_c   = state == IDLE ? (len > MEM_WORDS ? MEM_WORDS : len) : len_q;
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = len_c == '0 ? DRAIN : WRITE;
            WRITE:   if (idx == len_q - 1'b1) state_n = READ;
            READ:    if (idx == len_q - 1'b1) state_n = DRAIN;
            DRAIN:   if (idx == len_t'(RD_LAT)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        idx_n = state_n == state ? idx + 1'b1 : '0;
    end

    // state and per-phase word index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // registered bus and status, computed from the next state so they line up with the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            seed_q  <= '0;
            len_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_exp  <= '0;
        end else begin
            base_q <= base_c;
            seed_q <= seed_c;
            len_q  <= len_c;
            busy   <= state_n != IDLE;
            done   <= state == DRAIN && state_n == IDLE;
            we_q   <= state_n == WRITE;
            if (state_n == WRITE || state_n == READ) addr_q <= base_c + addr_t'(idx_n);
            if (state_n == WRITE) wdata_q <= seed_c + data_t'(idx_n);
            if (state_n == READ) rd_exp <= seed_c + data_t'(idx_n);
        end
    end

    mem_bist_initiator_rd_cmp_pipe #(.LAT(RD_LAT)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (state == READ),
        .in_addr  (addr_q),
        .in_exp   (rd_exp),
        .rdata    (mem.rdata),
        .mis      (mis),
        .mis_addr (mis_addr)
    );

    // results: cleared on an accepted start, saturating count, first failing address kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (state == IDLE && start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mis) begin
            if (err_cnt == '0) first_err_addr <= mis_addr;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb_mem_bist_initiator: directed checks of the BIST initiator against a behavioural SRAM
module tb_mem_bist_initiator;
    import mem_bist_initiator_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    addr_t base = '0;
    len_t  len = '0;
    data_t seed = '0;
    logic  busy, done;
    len_t  err_cnt;
    addr_t first_err_addr;
    data_t sram [16] = '{default: '0};
    logic  flip11 = 1'b0;
    logic  stuck7 = 1'b0;
    int    we_seen = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    lat, w0, done_seen;

    mem_bist_initiator_if mem();

    mem_bist_initiator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base           (base),
        .len            (len),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .mem            (mem)
    );

    always #5 clk = ~clk;

    // SRAM with registered read and optional fault injection on the read path
    always @(posedge clk) begin
        if (mem.we) begin
            sram[mem.addr] <= mem.wdata;
            we_seen <= we_seen + 1;
        end
        mem.rdata <= (sram[mem.addr] ^ {7'b0, flip11 && mem.addr == 4'd11}) | {stuck7, 7'b0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input addr_t b, input len_t l, input data_t s, output int cycles);
        base  = b;
        len   = l;
        seed  = s;
        start = 1'b1;
        step();
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_addr, 0);
        check("rst_we", mem.we, 0);
        check("rst_addr", mem.addr, 0);
        check("rst_wdata", mem.wdata, 0);
        rst_n = 1'b1;
        step();

        base  = 4'd0;
        len   = 5'd16;
        seed  = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t1_we_mid", mem.we, 1);
        check("t1_busy_mid", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_we_rst", mem.we, 0);
        check("t1_busy_rst", busy, 0);
        step();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) done_seen++;
        end
        check("t1_no_done", done_seen, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_we", mem.we, 0);

        w0 = we_seen;
        run(4'd4, 5'd1, 8'd88, lat);
        check("t2_latency", lat, 4);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_mem4", sram[4], 88);
        check("t2_writes", we_seen - w0, 1);

        run(4'd14, 5'd4, 8'd254, lat);
        check("t3_latency", lat, 10);
        check("t3_mem14", sram[14], 254);
        check("t3_mem15", sram[15], 255);
        check("t3_mem0", sram[0], 0);
        check("t3_mem1", sram[1], 1);
        check("t3_err_cnt", err_cnt, 0);

        flip11 = 1'b1;
        run(4'd8, 5'd8, 8'd0, lat);
        flip11 = 1'b0;
        check("t4_latency", lat, 18);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_first_err", first_err_addr, 11);

        stuck7 = 1'b1;
        run(4'd5, 5'd16, 8'd0, lat);
        stuck7 = 1'b0;
        check("t5_latency", lat, 34);
        check("t5_err_cnt", err_cnt, 16);
        check("t5_first_err", first_err_addr, 5);
        step();
        step();
        step();
        check("t5_hold_cnt", err_cnt, 16);
        check("t5_hold_first", first_err_addr, 5);

        w0 = we_seen;
        run(4'd0, 5'd31, 8'd100, lat);
        check("clamp_latency", lat, 34);
        check("clamp_writes", we_seen - w0, 16);
        check("clamp_mem0", sram[0], 100);
        check("clamp_mem15", sram[15], 115);
        check("clamp_err_cleared", err_cnt, 0);

        w0 = we_seen;
        base  = 4'd3;
        len   = 5'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_busy", busy, 1);
        base  = 4'd0;
        len   = 5'd16;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        check("t6_latency", lat, 2);
        check("t6_no_writes", we_seen - w0, 0);
        base  = 4'd4;
        len   = 5'd1;
        seed  = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_restart_busy", busy, 1);
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        check("t6_restart_latency", lat, 4);
        check("t6_restart_mem4", sram[4], 7);
        check("t6_restart_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
